// File: rtl/fifo_param.sv
// Single-clock synchronous FIFO with parametrised width/depth, threshold flags,
// occupancy count, registered read port with valid strobe and sticky error flags.
module fifo_param #(
  parameter int  DATA_WIDTH = 6,
  parameter int  DEPTH      = 8,
  parameter int  AF_THRESH  = 6,
  parameter int  AE_THRESH  = 2,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_wr,
  input  logic                  fifo_rd,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [CW-1:0]         count,
  output logic                  err_full,
  output logic                  err_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_ok;
  logic                  rd_ok;

  // Status flags decode the registered count, so they never glitch on pointer wrap.
  always_comb begin
    fifo_empty   = (count == '0);
    fifo_full    = (count == CW'(DEPTH));
    almost_empty = (count <= CW'(AE_THRESH));
    almost_full  = (count >= CW'(AF_THRESH));
  end

  // A full FIFO still takes a write when the same edge pops a word.
  assign wr_ok = fifo_wr & (~fifo_full | fifo_rd);
  assign rd_ok = fifo_rd & ~fifo_empty;

  // NOTE: storage has no reset so it can map onto RAM; count/pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered read port: data_out holds its last word when nothing is popped.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_ok;
      if (rd_ok) data_out <= mem[rd_ptr];
    end
  end

  // Sticky errors; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      err_full  <= 1'b0;
      err_empty <= 1'b0;
    end else begin
      err_full  <= (fifo_wr & ~wr_ok) | (err_full  & ~err_clr);
      err_empty <= (fifo_rd & ~rd_ok) | (err_empty & ~err_clr);
    end
  end

endmodule
